// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared constants for the ALU sequencer: ALU opcodes,
//                sequencer-only opcodes, flag bit positions, FSM states.
//  Options     : ALU_SEQ_STEP_EN adds the PAUSE state (encoding reserved
//                here in every build).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int DATA_W = 4;

    // Opcodes executed by the external ALU
    localparam logic [3:0] INS_ADD    = 4'b0000;
    localparam logic [3:0] INS_SUB    = 4'b0001;
    localparam logic [3:0] INS_AND    = 4'b0010;
    localparam logic [3:0] INS_OR     = 4'b0011;
    localparam logic [3:0] INS_XOR    = 4'b0100;
    localparam logic [3:0] INS_NAND   = 4'b0101;
    localparam logic [3:0] INS_NOR    = 4'b0110;
    localparam logic [3:0] INS_XNOR   = 4'b0111;
    localparam logic [3:0] INS_NOT    = 4'b1000;
    localparam logic [3:0] INS_LSHIFT = 4'b1001;
    localparam logic [3:0] INS_RSHIFT = 4'b1010;

    // Opcodes handled by the sequencer itself (1101/1110 are NOPs)
    localparam logic [3:0] OP_LDI  = 4'b1011;
    localparam logic [3:0] OP_BRZ  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Bit positions inside the {Z,N,C,V} flag vector
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_DONE  = 3'd3,
        ST_PAUSE = 3'd4
    } seqState_t;

    // True for opcodes that go through the ALU and update the flags
    function automatic logic isAluOp(input logic [3:0] op);
        return (op <= INS_RSHIFT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_regfile
//  Description : NREG x 4-bit register file, two combinational operand read
//                ports, one combinational read-back port, one synchronous
//                write port, asynchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iWe,
    input  logic [1:0]        ivWrAddr,
    input  logic [DATA_W-1:0] ivWrData,
    input  logic [1:0]        ivRdAddrA,
    input  logic [1:0]        ivRdAddrB,
    input  logic [1:0]        ivRdAddrC,
    output logic [DATA_W-1:0] ovRdDataA,
    output logic [DATA_W-1:0] ovRdDataB,
    output logic [DATA_W-1:0] ovRdDataC
);

    logic [DATA_W-1:0] r_regs [NREG];

    // Single write port; the whole file clears on reset
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (iWe) begin
            r_regs[ivWrAddr] <= ivWrData;
        end
    end

    // Reads see pre-edge contents, so rd==ra/rb reads the old value
    assign ovRdDataA = r_regs[ivRdAddrA];
    assign ovRdDataB = r_regs[ivRdAddrB];
    assign ovRdDataC = r_regs[ivRdAddrC];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Program-driven controller for the external 4-bit ALU.
//                Fetches 12-bit instructions from a synchronous ROM, drives
//                the ALU from a 4x4 register file, writes results back and
//                keeps registered {Z,N,C,V} flags.
//  Options     : ALU_SEQ_STEP_EN - adds iStep and a PAUSE state after every
//                non-HALT instruction (single-step debug).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int NREG   = 4
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iStart,
`ifdef ALU_SEQ_STEP_EN
    input  logic              iStep,
`endif
    output logic [ADDR_W-1:0] ovPc,
    input  logic [11:0]       ivInstr,
    output logic [3:0]        ovAluInstruccion,
    output logic [3:0]        ovAluA,
    output logic [3:0]        ovAluB,
    input  logic [3:0]        ivAluResultado,
    input  logic [3:0]        ivAluFlags,
    output logic [3:0]        ovFlags,
    input  logic [1:0]        ivRegSel,
    output logic [3:0]        ovRegOut,
    output logic              oBusy,
    output logic              oDone
);

    seqState_t         r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [3:0]        r_flags;
    logic              r_busy;
    logic              r_done;

    // Instruction fields, only meaningful while in EXEC
    logic [3:0]        w_op;
    logic [1:0]        w_rd;
    logic [1:0]        w_ra;
    logic [1:0]        w_rb;
    logic [3:0]        w_imm;
    logic [ADDR_W-1:0] w_target;
    logic              w_unusedBits;
    logic              w_exec;
    logic              w_isAlu;
    logic              w_we;
    logic [3:0]        w_wrData;
    logic [3:0]        w_rdA;
    logic [3:0]        w_rdB;

    assign w_op         = ivInstr[11:8];
    assign w_rd         = ivInstr[7:6];
    assign w_ra         = ivInstr[5:4];
    assign w_rb         = ivInstr[3:2];
    assign w_imm        = ivInstr[5:2];
    assign w_target     = ADDR_W'(ivInstr[5:0]);
    assign w_unusedBits = ^ivInstr[1:0];

    assign w_exec   = (r_state == ST_EXEC);
    assign w_isAlu  = isAluOp(w_op);
    assign w_we     = w_exec && (w_isAlu || (w_op == OP_LDI));
    assign w_wrData = w_isAlu ? ivAluResultado : w_imm;

    alu_seq_regfile #(
        .NREG      (NREG)
    ) u_regfile (
        .iClk      (iClk),
        .iReset    (iReset),
        .iWe       (w_we),
        .ivWrAddr  (w_rd),
        .ivWrData  (w_wrData),
        .ivRdAddrA (w_ra),
        .ivRdAddrB (w_rb),
        .ivRdAddrC (ivRegSel),
        .ovRdDataA (w_rdA),
        .ovRdDataB (w_rdB),
        .ovRdDataC (ovRegOut)
    );

    // ALU is only driven while an ALU-class instruction is executing
    always_comb begin
        ovAluInstruccion = '0;
        ovAluA           = '0;
        ovAluB           = '0;
        if (w_exec && w_isAlu) begin
            ovAluInstruccion = w_op;
            ovAluA           = w_rdA;
            ovAluB           = w_rdB;
        end
    end

    // Sequencer FSM: PC, flags and the busy/done status are all registered
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_flags <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (iStart) begin
                        r_pc    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_isAlu) begin
                        r_flags <= ivAluFlags;
                    end
                    if (w_op == OP_HALT) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        // BRZ looks at the flags from the previous ALU op
                        if ((w_op == OP_BRZ) && r_flags[FLAG_Z]) begin
                            r_pc <= w_target;
                        end else begin
                            r_pc <= r_pc + ADDR_W'(1);
                        end
`ifdef ALU_SEQ_STEP_EN
                        r_state <= ST_PAUSE;
`else
                        r_state <= ST_FETCH;
`endif
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
`ifdef ALU_SEQ_STEP_EN
                ST_PAUSE: begin
                    if (iStep) begin
                        r_state <= ST_FETCH;
                    end
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ovPc    = r_pc;
    assign ovFlags = r_flags;
    assign oBusy   = r_busy;
    assign oDone   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer with a synchronous
//                ROM model and a reference ALU. Expected fetch addresses and
//                completion cycles are queued when a program is started and
//                consumed as the sequencer fetches and finishes.
//  Options     : ALU_SEQ_STEP_EN - also exercises single-step PAUSE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
    import alu_seq_pkg::*;

`ifdef ALU_SEQ_STEP_EN
    localparam int c_period = 3;
`else
    localparam int c_period = 2;
`endif
    localparam logic [11:0] c_nop  = 12'hD00;
    localparam logic [11:0] c_halt = 12'hF00;

    logic        iClk     = 1'b0;
    logic        iReset   = 1'b1;
    logic        iStart   = 1'b0;
`ifdef ALU_SEQ_STEP_EN
    logic        iStep    = 1'b1;
`endif
    logic [5:0]  ovPc;
    logic [11:0] ivInstr;
    logic [3:0]  ovAluInstruccion;
    logic [3:0]  ovAluA;
    logic [3:0]  ovAluB;
    logic [3:0]  ivAluResultado;
    logic [3:0]  ivAluFlags;
    logic [3:0]  ovFlags;
    logic [1:0]  ivRegSel = 2'd0;
    logic [3:0]  ovRegOut;
    logic        oBusy;
    logic        oDone;

    logic [11:0] rom [64];
    logic [4:0]  aluWide;
    int          nPass  = 0;
    int          nTotal = 0;
    int          expDone[$];
    int          expPc[$];
    bit          sawDone;

    alu_sequencer dut (
        .iClk             (iClk),
        .iReset           (iReset),
        .iStart           (iStart),
`ifdef ALU_SEQ_STEP_EN
        .iStep            (iStep),
`endif
        .ovPc             (ovPc),
        .ivInstr          (ivInstr),
        .ovAluInstruccion (ovAluInstruccion),
        .ovAluA           (ovAluA),
        .ovAluB           (ovAluB),
        .ivAluResultado   (ivAluResultado),
        .ivAluFlags       (ivAluFlags),
        .ovFlags          (ovFlags),
        .ivRegSel         (ivRegSel),
        .ovRegOut         (ovRegOut),
        .oBusy            (oBusy),
        .oDone            (oDone)
    );

    always #5 iClk = ~iClk;

    // Synchronous program ROM: data valid one cycle after the address
    always @(posedge iClk) ivInstr <= rom[ovPc];

    // Reference ALU: Z on zero result, C = carry (ADD) / borrow (SUB),
    // N = borrow on SUB, V unused by the test programs
    always_comb begin
        aluWide        = '0;
        ivAluFlags     = '0;
        ivAluResultado = '0;
        case (ovAluInstruccion)
            INS_ADD:    begin
                aluWide = {1'b0, ovAluA} + {1'b0, ovAluB};
                ivAluFlags[FLAG_C] = aluWide[4];
            end
            INS_SUB:    begin
                aluWide = {1'b0, ovAluA - ovAluB};
                ivAluFlags[FLAG_N] = (ovAluA < ovAluB);
                ivAluFlags[FLAG_C] = (ovAluA < ovAluB);
            end
            INS_AND:    aluWide = {1'b0, ovAluA & ovAluB};
            INS_OR:     aluWide = {1'b0, ovAluA | ovAluB};
            INS_XOR:    aluWide = {1'b0, ovAluA ^ ovAluB};
            INS_NAND:   aluWide = {1'b0, ~(ovAluA & ovAluB)};
            INS_NOR:    aluWide = {1'b0, ~(ovAluA | ovAluB)};
            INS_XNOR:   aluWide = {1'b0, ~(ovAluA ^ ovAluB)};
            INS_NOT:    aluWide = {1'b0, ~ovAluA};
            INS_LSHIFT: aluWide = {1'b0, ovAluA << ovAluB};
            INS_RSHIFT: aluWide = {1'b0, ovAluA >> ovAluB};
            default:    aluWide = '0;
        endcase
        ivAluResultado     = aluWide[3:0];
        ivAluFlags[FLAG_Z] = (aluWide[3:0] == 4'd0);
    end

    function automatic logic [11:0] fAlu(input logic [3:0] op, input logic [1:0] rd,
                                         input logic [1:0] ra, input logic [1:0] rb);
        return {op, rd, ra, rb, 2'b00};
    endfunction

    function automatic logic [11:0] fLdi(input logic [1:0] rd, input logic [3:0] imm);
        return {OP_LDI, rd, imm, 2'b00};
    endfunction

    function automatic logic [11:0] fBrz(input logic [5:0] tgt);
        return {OP_BRZ, 2'b00, tgt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic checkReg(input logic [1:0] idx, input logic [3:0] exp);
        ivRegSel = idx;
        #1;
        check($sformatf("reg_r%0d", idx), ovRegOut, exp);
    endtask

    task automatic fillRom(input logic [11:0] word);
        for (int i = 0; i < 64; i++) rom[i] = word;
    endtask

    task automatic doReset();
        iReset = 1'b1;
        @(negedge iClk);
        iReset = 1'b0;
    endtask

    task automatic pushPcs(input int n);
        for (int i = 0; i < n; i++) expPc.push_back(i);
    endtask

    // Start a program and follow it to oDone. j counts negedges after the
    // edge that samples iStart (j=0 is the first FETCH).
    task automatic runProgram(input int nInstr, input int abortAt,
                              input int startAt, input int patchAt);
        bit seen = 1'b0;
        expDone.push_back(c_period * (nInstr - 1) + 2);
        @(negedge iClk) iStart = 1'b1;
        @(negedge iClk) iStart = 1'b0;
        for (int j = 0; j < 4000 && !seen; j++) begin
            if (j > 0) @(negedge iClk);
            if (j == abortAt) return;
            iStart = (j == startAt);
            if (j == patchAt) rom[0] = c_halt;
            if (oDone) begin
                seen = 1'b1;
                check("done_cycle", j, expDone.pop_front());
                check("busy_at_done", oBusy, 1'b0);
            end else if (j % c_period == 0) begin
                check("busy_run", oBusy, 1'b1);
                if (expPc.size() > 0) check("fetch_pc", ovPc, expPc.pop_front());
                else                  check("fetch_pc_extra", ovPc, 32'hFFFF_FFFF);
            end
        end
        iStart = 1'b0;
        check("done_seen", seen, 1'b1);
        expDone.delete();
        @(negedge iClk);
        check("done_pulse_end", oDone, 1'b0);
        check("busy_after", oBusy, 1'b0);
        check("pc_queue_empty", expPc.size(), 0);
        expPc.delete();
    endtask

    task automatic loadProg1();
        fillRom(c_halt);
        rom[0] = fLdi(2'd0, 4'd5);
        rom[1] = fLdi(2'd1, 4'd3);
        rom[2] = fAlu(INS_ADD, 2'd2, 2'd0, 2'd1);
        rom[3] = c_halt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge iClk);
        check("rst_pc", ovPc, 0);
        check("rst_busy", oBusy, 1'b0);
        check("rst_done", oDone, 1'b0);
        check("rst_flags", ovFlags, 4'd0);
        check("rst_alu_op", ovAluInstruccion, 4'd0);
        check("rst_alu_a", ovAluA, 4'd0);
        check("rst_alu_b", ovAluB, 4'd0);
        for (int i = 0; i < 4; i++) checkReg(2'(i), 4'd0);
        iReset = 1'b0;

        // ADD: 5 + 3 = 8
        loadProg1();
        pushPcs(4);
        runProgram(4, -1, -1, -1);
        checkReg(2'd0, 4'd5);
        checkReg(2'd1, 4'd3);
        checkReg(2'd2, 4'd8);
        check("add_flags", ovFlags, 4'b0000);

        // SUB: 3 - 5 = 1110, N and C set
        doReset();
        fillRom(c_halt);
        rom[0] = fLdi(2'd0, 4'd3);
        rom[1] = fLdi(2'd1, 4'd5);
        rom[2] = fAlu(INS_SUB, 2'd2, 2'd0, 2'd1);
        pushPcs(4);
        runProgram(4, -1, -1, -1);
        checkReg(2'd2, 4'b1110);
        check("sub_flags", ovFlags, 4'b0110);

        // Taken BRZ skips address 4; rd==ra read-before-write
        doReset();
        fillRom(c_halt);
        rom[0] = fLdi(2'd0, 4'd1);
        rom[1] = fLdi(2'd1, 4'd1);
        rom[2] = fAlu(INS_SUB, 2'd0, 2'd0, 2'd1);
        rom[3] = fBrz(6'd5);
        rom[4] = fLdi(2'd2, 4'd15);
        rom[5] = c_halt;
        expPc = '{0, 1, 2, 3, 5};
        runProgram(5, -1, -1, -1);
        checkReg(2'd0, 4'd0);
        checkReg(2'd2, 4'd0);
        check("brz_flags", ovFlags, 4'b1000);

        // Reset during EXEC of the ADD, then a clean rerun with a stray iStart
        doReset();
        loadProg1();
        pushPcs(4);
        runProgram(4, 5, -1, -1);
        expPc.delete();
        expDone.delete();
        iReset = 1'b1;
        #1;
        check("abort_busy", oBusy, 1'b0);
        check("abort_flags", ovFlags, 4'd0);
        check("abort_pc", ovPc, 0);
        check("abort_alu_op", ovAluInstruccion, 4'd0);
        for (int i = 0; i < 4; i++) checkReg(2'(i), 4'd0);
        @(negedge iClk);
        iReset  = 1'b0;
        sawDone = 1'b0;
        repeat (6) begin
            @(negedge iClk);
            if (oDone || oBusy) sawDone = 1'b1;
        end
        check("abort_no_done", sawDone, 1'b0);
        pushPcs(4);
        runProgram(4, -1, 3, -1);
        checkReg(2'd2, 4'd8);

        // PC wraps 63 -> 0; address 0 becomes HALT once first fetched
        doReset();
        fillRom(c_nop);
        pushPcs(64);
        expPc.push_back(0);
        runProgram(65, -1, -1, 1);
        check("wrap_flags", ovFlags, 4'd0);

`ifdef ALU_SEQ_STEP_EN
        // Single-step: hold in PAUSE until each iStep pulse
        doReset();
        loadProg1();
        iStep = 1'b0;
        @(negedge iClk) iStart = 1'b1;
        @(negedge iClk) iStart = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge iClk);
            @(negedge iClk);
            repeat (3) @(negedge iClk);
            check("pause_busy", oBusy, 1'b1);
            check("pause_done", oDone, 1'b0);
            check("pause_pc", ovPc, s + 1);
            checkReg(2'(s), (s == 0) ? 4'd5 : (s == 1) ? 4'd3 : 4'd8);
            iStep = 1'b1;
            @(negedge iClk) iStep = 1'b0;
        end
        @(negedge iClk);
        @(negedge iClk);
        check("step_done", oDone, 1'b1);
        iStep = 1'b1;
`endif

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
`default_nettype wire
